// File: rtl/idli_uarb_m.sv
// idli_uarb_m
//
// Round-robin arbiter sharing the UART receive slice stream between up to
// eight consumers. A grant covers one whole 16b beat (four 4b slices, aligned
// to the core slice counter) and the accept sent back to the receiver is
// frozen for the whole beat, so a consumer changing its mind mid-beat cannot
// corrupt the receiver's shift buffer.
//
// Parameters
//   NUM_REQ   number of requesters (2..8)
//   MAX_HOLD  declined beats a grant may stay locked before forced release (1..15)
//
// Ports
//   i_uarb_gck       core clock
//   i_uarb_rst_n     synchronous active-low reset
//   i_uarb_ctr       slice counter, 3 = last slice of a beat
//   i_uarb_urx_data  current slice from the receiver
//   i_uarb_urx_vld   receiver holds a full 16b word
//   o_uarb_urx_acp   accept back to the receiver
//   i_uarb_req       per-requester request
//   i_uarb_acp       per-requester accept, sampled at ctr==0
//   o_uarb_gnt       one-hot registered grant
//   o_uarb_vld       per-requester data valid
//   o_uarb_stats     (IDLI_UARB_STATS_EN only) NUM_REQ x 8b consumed-beat counters
//   o_uarb_data      broadcast slice (combinational pass-through)
//
// Build option
//   IDLI_UARB_STATS_EN  adds saturating per-requester consumed-beat counters.

module idli_uarb_m #(
    parameter int NUM_REQ  = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                 i_uarb_gck,
    input  logic                 i_uarb_rst_n,
    input  logic [1:0]           i_uarb_ctr,
    input  logic [3:0]           i_uarb_urx_data,
    input  logic                 i_uarb_urx_vld,
    output logic                 o_uarb_urx_acp,
    input  logic [NUM_REQ-1:0]   i_uarb_req,
    input  logic [NUM_REQ-1:0]   i_uarb_acp,
    output logic [NUM_REQ-1:0]   o_uarb_gnt,
    output logic [NUM_REQ-1:0]   o_uarb_vld,
`ifdef IDLI_UARB_STATS_EN
    output logic [NUM_REQ*8-1:0] o_uarb_stats,
`endif
    output logic [3:0]           o_uarb_data
);

    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_REQ - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [PTR_W:0]    NUM_EXT   = (PTR_W + 1)'(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE      = NUM_REQ'(1);

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t              state_q;
    logic [NUM_REQ-1:0]  gnt_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                acp_q;
    logic [HOLD_W-1:0]   hold_q;

    logic [PTR_W-1:0]    gnt_idx;
    logic [PTR_W-1:0]    win_idx;
    logic                win_found;
    logic [PTR_W-1:0]    ptr_after;
    logic                beat_end;
    logic                consumed;

    // Index of the current grant holder, recovered from the one-hot grant.
    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx = PTR_W'(i);
            end
        end
    end

    // Round-robin winner: first set request scanning upward from ptr_q.
    // The scan runs from the farthest offset down so the nearest one wins;
    // the wrap is explicit because NUM_REQ need not be a power of two.
    always_comb begin
        logic [PTR_W:0] pos;
        pos       = '0;
        win_idx   = ptr_q;
        win_found = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            pos = {1'b0, ptr_q} + (PTR_W + 1)'(k);
            if (pos >= NUM_EXT) begin
                pos = pos - NUM_EXT;
            end
            if (i_uarb_req[pos[PTR_W-1:0]]) begin
                win_idx   = pos[PTR_W-1:0];
                win_found = 1'b1;
            end
        end
    end

    assign ptr_after = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
    assign beat_end  = (state_q == BUSY) && (i_uarb_ctr == 2'd3);
    assign consumed  = beat_end && acp_q;

    assign o_uarb_gnt  = gnt_q;
    assign o_uarb_vld  = gnt_q & {NUM_REQ{i_uarb_urx_vld}};
    assign o_uarb_data = i_uarb_urx_data;

    // At slice 0 the live accept goes straight through; for slices 1..3 the
    // value captured at slice 0 is replayed so the receiver sees one decision.
    assign o_uarb_urx_acp = (state_q == BUSY) &&
                            ((i_uarb_ctr == 2'd0) ? i_uarb_acp[gnt_idx] : acp_q);

    // Arbitration and end-of-beat state machine.
    always_ff @(posedge i_uarb_gck) begin
        if (!i_uarb_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            ptr_q   <= '0;
            acp_q   <= 1'b0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if ((i_uarb_ctr == 2'd3) && i_uarb_urx_vld && win_found) begin
                        gnt_q   <= ONE << win_idx;
                        hold_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_uarb_ctr == 2'd0) begin
                        acp_q <= i_uarb_acp[gnt_idx];
                    end
                    if (i_uarb_ctr == 2'd3) begin
                        // Consumed and forced release both move the pointer
                        // past the holder; a dropped request does not.
                        if (acp_q || (hold_q == HOLD_LAST)) begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                            ptr_q   <= ptr_after;
                        end else if (i_uarb_req[gnt_idx]) begin
                            hold_q <= hold_q + 1'b1;
                        end else begin
                            state_q <= IDLE;
                            gnt_q   <= '0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef IDLI_UARB_STATS_EN
    logic [NUM_REQ*8-1:0] stats_q;

    // Saturating per-requester count of consumed beats; forced releases
    // never reach here because they end with acp_q low.
    always_ff @(posedge i_uarb_gck) begin
        if (!i_uarb_rst_n) begin
            stats_q <= '0;
        end else if (consumed) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (gnt_q[i] && (stats_q[i*8 +: 8] != 8'hFF)) begin
                    stats_q[i*8 +: 8] <= stats_q[i*8 +: 8] + 8'd1;
                end
            end
        end
    end

    assign o_uarb_stats = stats_q;
`else
    // Without statistics the consumed-beat strobe has no further use.
    logic unused_consumed;
    assign unused_consumed = consumed;
`endif

endmodule

// File: tb/tb_idli_uarb_m.sv
// tb_idli_uarb_m
//
// Directed self-checking bench for idli_uarb_m with NUM_REQ=3, MAX_HOLD=2.
// The bench drives the slice counter itself; each advance moves to the next
// slice and presents data = slice index + 1.
//
// Build option IDLI_UARB_STATS_EN also exercises the statistics counters.

module tb_idli_uarb_m;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] ctr = 2'd0;
    logic [3:0] urx_data = 4'd1;
    logic       urx_vld = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] acp = 3'b000;

    logic       urx_acp;
    logic [2:0] gnt;
    logic [2:0] vld;
    logic [3:0] data;
`ifdef IDLI_UARB_STATS_EN
    logic [23:0] stats;
`endif

    int checks = 0;
    int errors = 0;

    idli_uarb_m #(
        .NUM_REQ  (3),
        .MAX_HOLD (2)
    ) dut (
        .i_uarb_gck      (clk),
        .i_uarb_rst_n    (rst_n),
        .i_uarb_ctr      (ctr),
        .i_uarb_urx_data (urx_data),
        .i_uarb_urx_vld  (urx_vld),
        .o_uarb_urx_acp  (urx_acp),
        .i_uarb_req      (req),
        .i_uarb_acp      (acp),
        .o_uarb_gnt      (gnt),
        .o_uarb_vld      (vld),
`ifdef IDLI_UARB_STATS_EN
        .o_uarb_stats    (stats),
`endif
        .o_uarb_data     (data)
    );

    always #5 clk = ~clk;

    // Move to the next slice just after the clock edge.
    task automatic adv();
        @(posedge clk);
        #1;
        ctr      = ctr + 2'd1;
        urx_data = {2'b00, ctr} + 4'd1;
    endtask

    task automatic goto3();
        for (int i = 0; i < 4 && ctr != 2'd3; i++) adv();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 3'b000;
        acp   = 3'b000;
        adv();
        adv();
        rst_n = 1'b1;
    endtask

    // Starting in a ctr==3 cycle, drive one beat. r also decides the end of
    // the previous beat, since it is applied during this ctr==3 cycle.
    task automatic run_beat(input logic [2:0] r, input logic [2:0] a,
                            output logic [2:0] g, output logic [2:0] v,
                            output logic all_acp, output logic any_acp);
        req     = r;
        acp     = a;
        urx_vld = 1'b1;
        g       = 3'b000;
        v       = 3'b000;
        all_acp = 1'b1;
        any_acp = 1'b0;
        for (int k = 0; k < 4; k++) begin
            adv();
            #1;
            if (k == 0) begin
                g = gnt;
                v = vld;
            end
            all_acp = all_acp & urx_acp;
            any_acp = any_acp | urx_acp;
        end
    endtask

    task automatic test_reset();
        urx_vld = 1'b1;
        req     = 3'b111;
        acp     = 3'b111;
        adv();
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_gnt: got %b expected %b", gnt, 3'b000); end
        checks++; if (vld !== 3'b000) begin errors++; $display("[TB] FAIL reset_vld: got %b expected %b", vld, 3'b000); end
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL reset_urx_acp: got %b expected %b", urx_acp, 1'b0); end
        checks++; if (data !== 4'd2) begin errors++; $display("[TB] FAIL reset_data: got %0d expected %0d", data, 2); end
        goto3();
        adv();
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL reset_no_arb: got %b expected %b", gnt, 3'b000); end
        rst_n   = 1'b1;
        req     = 3'b000;
        acp     = 3'b000;
        urx_vld = 1'b0;
    endtask

    task automatic test_single();
        logic [2:0] g, v;
        logic       aa, an;
        goto3();
        req     = 3'b001;
        acp     = 3'b001;
        urx_vld = 1'b1;
        for (int k = 0; k < 4; k++) begin
            adv();
            #1;
            if (k == 0) begin
                checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL single_gnt: got %b expected %b", gnt, 3'b001); end
            end
            checks++; if (vld !== 3'b001) begin errors++; $display("[TB] FAIL single_vld slice %0d: got %b expected %b", k, vld, 3'b001); end
            checks++; if (data !== 4'(k + 1)) begin errors++; $display("[TB] FAIL single_data slice %0d: got %0d expected %0d", k, data, k + 1); end
            checks++; if (urx_acp !== 1'b1) begin errors++; $display("[TB] FAIL single_urx_acp slice %0d: got %b expected %b", k, urx_acp, 1'b1); end
        end
        adv();
        #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL single_idle_gnt: got %b expected %b", gnt, 3'b000); end
        checks++; if (vld !== 3'b000) begin errors++; $display("[TB] FAIL single_idle_vld: got %b expected %b", vld, 3'b000); end
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL single_idle_urx_acp: got %b expected %b", urx_acp, 1'b0); end
        goto3();
        // Pointer now 1: requester 1 wins over 0.
        run_beat(3'b011, 3'b000, g, v, aa, an);
        checks++; if (g !== 3'b010) begin errors++; $display("[TB] FAIL single_ptr_gnt: got %b expected %b", g, 3'b010); end
        checks++; if (an !== 1'b0) begin errors++; $display("[TB] FAIL single_decline_acp: got %b expected %b", an, 1'b0); end
        // Requester 1 drops its request: release without moving the pointer.
        run_beat(3'b001, 3'b000, g, v, aa, an);
        checks++; if (g !== 3'b000) begin errors++; $display("[TB] FAIL drop_release_gnt: got %b expected %b", g, 3'b000); end
        run_beat(3'b011, 3'b010, g, v, aa, an);
        checks++; if (g !== 3'b010) begin errors++; $display("[TB] FAIL drop_ptr_kept_gnt: got %b expected %b", g, 3'b010); end
        checks++; if (aa !== 1'b1) begin errors++; $display("[TB] FAIL drop_consume_acp: got %b expected %b", aa, 1'b1); end
        run_beat(3'b000, 3'b000, g, v, aa, an);
        checks++; if (g !== 3'b000) begin errors++; $display("[TB] FAIL single_final_idle: got %b expected %b", g, 3'b000); end
    endtask

    task automatic test_round_robin();
        logic [2:0] g, v;
        logic       aa, an;
        logic [2:0] exp_g [0:7];
        exp_g = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001, 3'b000};
        do_reset();
        goto3();
        for (int b = 0; b < 8; b++) begin
            run_beat(3'b111, 3'b111, g, v, aa, an);
            checks++; if (g !== exp_g[b]) begin errors++; $display("[TB] FAIL rr_gnt beat %0d: got %b expected %b", b, g, exp_g[b]); end
            checks++; if (v !== exp_g[b]) begin errors++; $display("[TB] FAIL rr_vld beat %0d: got %b expected %b", b, v, exp_g[b]); end
        end
    endtask

    task automatic test_midbeat_acp();
        // Pointer is 1 after the round-robin sequence.
        req     = 3'b010;
        acp     = 3'b010;
        urx_vld = 1'b1;
        adv(); #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL drop_acp_gnt: got %b expected %b", gnt, 3'b010); end
        checks++; if (urx_acp !== 1'b1) begin errors++; $display("[TB] FAIL drop_acp_c0: got %b expected %b", urx_acp, 1'b1); end
        adv(); #1;
        checks++; if (urx_acp !== 1'b1) begin errors++; $display("[TB] FAIL drop_acp_c1: got %b expected %b", urx_acp, 1'b1); end
        adv(); acp = 3'b000; #1;
        checks++; if (urx_acp !== 1'b1) begin errors++; $display("[TB] FAIL drop_acp_c2: got %b expected %b", urx_acp, 1'b1); end
        adv(); #1;
        checks++; if (urx_acp !== 1'b1) begin errors++; $display("[TB] FAIL drop_acp_c3: got %b expected %b", urx_acp, 1'b1); end
        adv(); #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL drop_acp_consumed: got %b expected %b", gnt, 3'b000); end
        // Reverse: accept low at slice 0, high afterwards.
        goto3();
        adv(); #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL late_acp_gnt: got %b expected %b", gnt, 3'b010); end
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL late_acp_c0: got %b expected %b", urx_acp, 1'b0); end
        adv(); acp = 3'b010; #1;
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL late_acp_c1: got %b expected %b", urx_acp, 1'b0); end
        adv(); #1;
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL late_acp_c2: got %b expected %b", urx_acp, 1'b0); end
        adv(); #1;
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL late_acp_c3: got %b expected %b", urx_acp, 1'b0); end
        acp = 3'b000;
        adv(); #1;
        checks++; if (gnt !== 3'b010) begin errors++; $display("[TB] FAIL late_acp_declined: got %b expected %b", gnt, 3'b010); end
        goto3();
        req = 3'b000;
        adv(); #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL late_acp_release: got %b expected %b", gnt, 3'b000); end
        goto3();
    endtask

    task automatic test_hold_limit();
        logic [2:0] g, v;
        logic       aa, an;
        logic [2:0] r_tab [0:5];
        logic [2:0] a_tab [0:5];
        logic [2:0] exp_g [0:5];
        // Pointer is 2: first consume for requester 0 to bring it to 1.
        r_tab = '{3'b001, 3'b011, 3'b011, 3'b011, 3'b011, 3'b011};
        a_tab = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        exp_g = '{3'b001, 3'b000, 3'b010, 3'b010, 3'b000, 3'b001};
        for (int b = 0; b < 6; b++) begin
            run_beat(r_tab[b], a_tab[b], g, v, aa, an);
            checks++; if (g !== exp_g[b]) begin errors++; $display("[TB] FAIL hold_gnt beat %0d: got %b expected %b", b, g, exp_g[b]); end
        end
    endtask

    task automatic test_reset_midbeat();
        logic [2:0] g, v;
        logic       aa, an;
        // Requester 0 holds a declined grant from the previous scenario.
        req = 3'b011;
        acp = 3'b001;
        adv(); #1;
        checks++; if (gnt !== 3'b001) begin errors++; $display("[TB] FAIL midrst_pre_gnt: got %b expected %b", gnt, 3'b001); end
        adv();
        rst_n = 1'b0;
        adv(); #1;
        checks++; if (gnt !== 3'b000) begin errors++; $display("[TB] FAIL midrst_gnt: got %b expected %b", gnt, 3'b000); end
        checks++; if (vld !== 3'b000) begin errors++; $display("[TB] FAIL midrst_vld: got %b expected %b", vld, 3'b000); end
        checks++; if (urx_acp !== 1'b0) begin errors++; $display("[TB] FAIL midrst_urx_acp: got %b expected %b", urx_acp, 1'b0); end
        checks++; if (data !== 4'd3) begin errors++; $display("[TB] FAIL midrst_data: got %0d expected %0d", data, 3); end
        rst_n = 1'b1;
        goto3();
        // Pointer back at 0: requester 1 beats 2.
        run_beat(3'b110, 3'b000, g, v, aa, an);
        checks++; if (g !== 3'b010) begin errors++; $display("[TB] FAIL midrst_ptr_gnt: got %b expected %b", g, 3'b010); end
        run_beat(3'b000, 3'b000, g, v, aa, an);
        checks++; if (g !== 3'b000) begin errors++; $display("[TB] FAIL midrst_release: got %b expected %b", g, 3'b000); end
    endtask

`ifdef IDLI_UARB_STATS_EN
    task automatic test_stats();
        logic [2:0] g, v;
        logic       aa, an;
        do_reset();
        #1;
        checks++; if (stats !== 24'd0) begin errors++; $display("[TB] FAIL stats_reset: got %h expected %h", stats, 24'd0); end
        goto3();
        for (int b = 0; b < 20; b++) run_beat(3'b001, 3'b001, g, v, aa, an);
        checks++; if (stats[7:0] !== 8'd10) begin errors++; $display("[TB] FAIL stats_count10: got %0d expected %0d", stats[7:0], 10); end
        for (int b = 0; b < 580; b++) run_beat(3'b001, 3'b001, g, v, aa, an);
        checks++; if (stats[7:0] !== 8'd255) begin errors++; $display("[TB] FAIL stats_saturate: got %0d expected %0d", stats[7:0], 255); end
        checks++; if (stats[23:8] !== 16'd0) begin errors++; $display("[TB] FAIL stats_others: got %h expected %h", stats[23:8], 16'd0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_midbeat_acp();
        test_hold_limit();
        test_reset_midbeat();
`ifdef IDLI_UARB_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
